// File: rtl/decode_issue_queue.sv
// decode_issue_queue
//   In-order circular queue between the A/B decoders and dependency resolution.
//   Accepts up to two decoded instructions per cycle (A older than B) and issues
//   up to two per cycle from the head, oldest first. The issue registers read
//   the pre-update queue state, so an entry never bypasses straight to issue.
//   queueStall_o is a registered near-full flag. It keeps four slots free so
//   the pairs already in flight through the registered stall unit still fit.

module decode_issue_queue #(
    parameter int DEPTH   = 8,
    parameter int INSTR_W = 64
) (
    input  logic                     clock_i,
    input  logic                     reset_i,
    input  logic                     flush_i,
    input  logic                     decAValid_i,
    input  logic [INSTR_W-1:0]       decAInstr_i,
    input  logic                     decBValid_i,
    input  logic [INSTR_W-1:0]       decBInstr_i,
    input  logic                     issueStall_i,
    output logic                     queueStall_o,
    output logic                     issueAValid_o,
    output logic [INSTR_W-1:0]       issueAInstr_o,
    output logic                     issueBValid_o,
    output logic [INSTR_W-1:0]       issueBInstr_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] DEPTH_C     = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] STALL_LIMIT = CNT_W'(DEPTH - 4);
    localparam logic [CNT_W-1:0] ONE_C       = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO_C       = CNT_W'(2);

    logic [INSTR_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [CNT_W-1:0]   count;

    logic [1:0]         nEnq;
    logic [1:0]         nAcc;
    logic [1:0]         nDeq;
    logic [CNT_W-1:0]   space;
    logic               dropEnq;
    logic               accEnq;
    logic               issueFire;
    logic               hasOne;
    logic               hasTwo;
    logic [CNT_W-1:0]   countNext;
    logic [PTR_W-1:0]   tailPlus1;
    logic [PTR_W-1:0]   headPlus1;
    logic [INSTR_W-1:0] wrData0;

    assign count_o = count;

    // Enqueue acceptance, dequeue amount and next occupancy.
    // The space check deliberately ignores same-cycle pops.
    always_comb begin
        nEnq      = {1'b0, decAValid_i} + {1'b0, decBValid_i};
        space     = DEPTH_C - count;
        dropEnq   = (CNT_W'(nEnq) > space);
        accEnq    = !flush_i && !dropEnq && (nEnq != 2'd0);
        nAcc      = accEnq ? nEnq : 2'd0;
        hasOne    = (count >= ONE_C);
        hasTwo    = (count >= TWO_C);
        issueFire = !flush_i && !issueStall_i;
        nDeq      = 2'd0;
        if (issueFire) begin
            if (hasTwo) begin
                nDeq = 2'd2;
            end else if (hasOne) begin
                nDeq = 2'd1;
            end
        end
        countNext = count + CNT_W'(nAcc) - CNT_W'(nDeq);
        if (flush_i) begin
            countNext = '0;
        end
        tailPlus1 = tail + PTR_W'(1);
        headPlus1 = head + PTR_W'(1);
        // When only B is valid it takes the first free slot.
        wrData0   = decAValid_i ? decAInstr_i : decBInstr_i;
    end

    // Storage writes: slot 0 at tail, slot 1 at tail+1 only for a full pair.
    always_ff @(posedge clock_i) begin
        if (accEnq) begin
            mem[tail] <= wrData0;
            if (nEnq == 2'd2) begin
                mem[tailPlus1] <= decBInstr_i;
            end
        end
    end

    // Head/tail pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(nDeq);
            tail  <= tail + PTR_W'(nAcc);
            count <= countNext;
        end
    end

    // Issue registers: load from head/head+1 when not held, hold otherwise.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            issueAValid_o <= 1'b0;
            issueAInstr_o <= '0;
            issueBValid_o <= 1'b0;
            issueBInstr_o <= '0;
        end else if (flush_i) begin
            issueAValid_o <= 1'b0;
            issueAInstr_o <= '0;
            issueBValid_o <= 1'b0;
            issueBInstr_o <= '0;
        end else if (!issueStall_i) begin
            issueAValid_o <= hasOne;
            issueAInstr_o <= hasOne ? mem[head] : '0;
            issueBValid_o <= hasTwo;
            issueBInstr_o <= hasTwo ? mem[headPlus1] : '0;
        end
    end

    // Registered near-full flag, computed from next occupancy.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            queueStall_o <= 1'b0;
        end else if (flush_i) begin
            queueStall_o <= 1'b0;
        end else begin
            queueStall_o <= (countNext > STALL_LIMIT);
        end
    end

    // Sticky overflow; a flush neither sets nor clears it.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            overflow_o <= 1'b0;
        end else if (!flush_i && dropEnq) begin
            overflow_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_decode_issue_queue.sv
// Directed bench for decode_issue_queue (DEPTH=8, INSTR_W=64).
module tb_decode_issue_queue;

    localparam int DEPTH   = 8;
    localparam int INSTR_W = 64;

    logic               clock_i = 1'b0;
    logic               reset_i;
    logic               flush_i;
    logic               decAValid_i;
    logic [INSTR_W-1:0] decAInstr_i;
    logic               decBValid_i;
    logic [INSTR_W-1:0] decBInstr_i;
    logic               issueStall_i;
    logic               queueStall_o;
    logic               issueAValid_o;
    logic [INSTR_W-1:0] issueAInstr_o;
    logic               issueBValid_o;
    logic [INSTR_W-1:0] issueBInstr_o;
    logic [3:0]         count_o;
    logic               overflow_o;

    int nAsserts = 0;
    int nFail    = 0;

    decode_issue_queue #(.DEPTH(DEPTH), .INSTR_W(INSTR_W)) dut (
        .clock_i       (clock_i),
        .reset_i       (reset_i),
        .flush_i       (flush_i),
        .decAValid_i   (decAValid_i),
        .decAInstr_i   (decAInstr_i),
        .decBValid_i   (decBValid_i),
        .decBInstr_i   (decBInstr_i),
        .issueStall_i  (issueStall_i),
        .queueStall_o  (queueStall_o),
        .issueAValid_o (issueAValid_o),
        .issueAInstr_o (issueAInstr_o),
        .issueBValid_o (issueBValid_o),
        .issueBInstr_o (issueBInstr_o),
        .count_o       (count_o),
        .overflow_o    (overflow_o)
    );

    always #5 clock_i = ~clock_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    task automatic drive(input logic av, input logic [63:0] ai, input logic bv, input logic [63:0] bi);
        decAValid_i = av;
        decAInstr_i = ai;
        decBValid_i = bv;
        decBInstr_i = bi;
    endtask

    task automatic chkIssue(input string tag, input logic av, input logic [63:0] ai,
                            input logic bv, input logic [63:0] bi);
        chk({tag, "_aValid"}, 64'(issueAValid_o), 64'(av));
        if (av) chk({tag, "_aInstr"}, issueAInstr_o, ai);
        chk({tag, "_bValid"}, 64'(issueBValid_o), 64'(bv));
        if (bv) chk({tag, "_bInstr"}, issueBInstr_o, bi);
    endtask

    initial begin
        int cyc;
        int sent;
        int nextExp;
        logic stallThis;

        // ---- 1: reset with random inputs ----
        reset_i      = 1'b0;
        flush_i      = 1'b0;
        issueStall_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'($urandom), {$urandom, $urandom}, 1'($urandom), {$urandom, $urandom});
            issueStall_i = 1'($urandom);
            tick();
        end
        chk("rst_count", 64'(count_o), 64'd0);
        chk("rst_qstall", 64'(queueStall_o), 64'd0);
        chk("rst_ovf", 64'(overflow_o), 64'd0);
        chk("rst_aValid", 64'(issueAValid_o), 64'd0);
        chk("rst_aInstr", issueAInstr_o, 64'd0);
        chk("rst_bValid", 64'(issueBValid_o), 64'd0);
        chk("rst_bInstr", issueBInstr_o, 64'd0);
        drive(1'b0, 64'd0, 1'b0, 64'd0);
        issueStall_i = 1'b0;
        #3 reset_i = 1'b1;
        tick();

        drive(1'b1, 64'h11, 1'b1, 64'h22);
        tick();
        chk("t1_count2", 64'(count_o), 64'd2);
        chkIssue("t1_noBypass", 1'b0, 64'd0, 1'b0, 64'd0);
        drive(1'b0, 64'd0, 1'b0, 64'd0);
        tick();
        chkIssue("t1_issue", 1'b1, 64'h11, 1'b1, 64'h22);
        chk("t1_count0", 64'(count_o), 64'd0);

        // ---- 2: only B valid ----
        drive(1'b0, 64'd0, 1'b1, 64'h33);
        tick();
        chk("t2_count1", 64'(count_o), 64'd1);
        drive(1'b0, 64'd0, 1'b0, 64'd0);
        tick();
        chkIssue("t2_issue", 1'b1, 64'h33, 1'b0, 64'd0);
        chk("t2_count0", 64'(count_o), 64'd0);

        // ---- 3: enqueue under stall, issue outputs frozen ----
        drive(1'b1, 64'h44, 1'b0, 64'd0);
        tick();
        drive(1'b0, 64'd0, 1'b0, 64'd0);
        tick();
        chkIssue("t3_pre", 1'b1, 64'h44, 1'b0, 64'd0);
        issueStall_i = 1'b1;
        drive(1'b1, 64'hA0, 1'b1, 64'hA1);
        tick();
        chk("t3_count2", 64'(count_o), 64'd2);
        chk("t3_qs2", 64'(queueStall_o), 64'd0);
        chkIssue("t3_frz2", 1'b1, 64'h44, 1'b0, 64'd0);
        drive(1'b1, 64'hA2, 1'b1, 64'hA3);
        tick();
        chk("t3_count4", 64'(count_o), 64'd4);
        chk("t3_qs4", 64'(queueStall_o), 64'd0);
        drive(1'b1, 64'hA4, 1'b1, 64'hA5);
        tick();
        chk("t3_count6", 64'(count_o), 64'd6);
        chk("t3_qs6", 64'(queueStall_o), 64'd1);
        chkIssue("t3_frz6", 1'b1, 64'h44, 1'b0, 64'd0);

        // ---- 4: overflow at count 7, then drain ----
        drive(1'b1, 64'hA6, 1'b0, 64'd0);
        tick();
        chk("t4_count7", 64'(count_o), 64'd7);
        chk("t4_ovf0", 64'(overflow_o), 64'd0);
        drive(1'b1, 64'hE0, 1'b1, 64'hE1);
        tick();
        chk("t4_dropCount", 64'(count_o), 64'd7);
        chk("t4_ovf1", 64'(overflow_o), 64'd1);
        drive(1'b0, 64'd0, 1'b0, 64'd0);
        issueStall_i = 1'b0;
        tick();
        chkIssue("t4_d1", 1'b1, 64'hA0, 1'b1, 64'hA1);
        chk("t4_d1count", 64'(count_o), 64'd5);
        chk("t4_d1qs", 64'(queueStall_o), 64'd1);
        tick();
        chkIssue("t4_d2", 1'b1, 64'hA2, 1'b1, 64'hA3);
        chk("t4_d2count", 64'(count_o), 64'd3);
        chk("t4_d2qs", 64'(queueStall_o), 64'd0);
        tick();
        chkIssue("t4_d3", 1'b1, 64'hA4, 1'b1, 64'hA5);
        tick();
        chkIssue("t4_d4", 1'b1, 64'hA6, 1'b0, 64'd0);
        chk("t4_d4count", 64'(count_o), 64'd0);
        chk("t4_ovfSticky", 64'(overflow_o), 64'd1);

        // ---- async reset mid-operation ----
        drive(1'b1, 64'h55, 1'b1, 64'h66);
        tick();
        drive(1'b0, 64'd0, 1'b0, 64'd0);
        chk("ar_pre", 64'(count_o), 64'd2);
        #2 reset_i = 1'b0;
        #1;
        chk("ar_count", 64'(count_o), 64'd0);
        chk("ar_ovf", 64'(overflow_o), 64'd0);
        chk("ar_aValid", 64'(issueAValid_o), 64'd0);
        tick();
        #3 reset_i = 1'b1;
        tick();
        tick();
        chkIssue("ar_noIssue", 1'b0, 64'd0, 1'b0, 64'd0);

        // ---- 5: wrap-around stream with toggling stall ----
        cyc     = 0;
        sent    = 0;
        nextExp = 0;
        while (nextExp < 40 && cyc < 400) begin
            stallThis    = ((cyc / 3) % 2) == 1;
            issueStall_i = stallThis;
            if (sent < 20 && !queueStall_o) begin
                drive(1'b1, 64'(2 * sent), 1'b1, 64'(2 * sent + 1));
                sent++;
            end else begin
                drive(1'b0, 64'd0, 1'b0, 64'd0);
            end
            tick();
            cyc++;
            if (!stallThis) begin
                if (issueAValid_o) begin
                    chk("t5_orderA", issueAInstr_o, 64'(nextExp));
                    nextExp++;
                end
                if (issueBValid_o) begin
                    chk("t5_bNeedsA", 64'(issueAValid_o), 64'd1);
                    chk("t5_orderB", issueBInstr_o, 64'(nextExp));
                    nextExp++;
                end
            end
        end
        chk("t5_received", 64'(nextExp), 64'd40);
        chk("t5_ovf", 64'(overflow_o), 64'd0);
        chk("t5_count", 64'(count_o), 64'd0);

        // ---- 6: flush at count 5 with valid issue and valid inputs ----
        issueStall_i = 1'b0;
        drive(1'b0, 64'd0, 1'b0, 64'd0);
        tick();
        drive(1'b1, 64'h200, 1'b1, 64'h201);
        tick();
        drive(1'b1, 64'h202, 1'b1, 64'h203);
        tick();
        chkIssue("t6_pre", 1'b1, 64'h200, 1'b1, 64'h201);
        issueStall_i = 1'b1;
        drive(1'b1, 64'h204, 1'b1, 64'h205);
        tick();
        drive(1'b1, 64'h206, 1'b0, 64'd0);
        tick();
        chk("t6_count5", 64'(count_o), 64'd5);
        chk("t6_qs5", 64'(queueStall_o), 64'd1);
        flush_i      = 1'b1;
        issueStall_i = 1'b0;
        drive(1'b1, 64'h3F0, 1'b1, 64'h3F1);
        tick();
        chk("t6_count0", 64'(count_o), 64'd0);
        chk("t6_qs0", 64'(queueStall_o), 64'd0);
        chkIssue("t6_kill", 1'b0, 64'd0, 1'b0, 64'd0);
        chk("t6_ovf", 64'(overflow_o), 64'd0);
        flush_i = 1'b0;
        drive(1'b0, 64'd0, 1'b0, 64'd0);
        tick();
        chkIssue("t6_after1", 1'b0, 64'd0, 1'b0, 64'd0);
        tick();
        chkIssue("t6_after2", 1'b0, 64'd0, 1'b0, 64'd0);
        chk("t6_countEnd", 64'(count_o), 64'd0);

        // fresh entries after flush start from a clean queue
        drive(1'b1, 64'h77, 1'b0, 64'd0);
        tick();
        drive(1'b0, 64'd0, 1'b0, 64'd0);
        tick();
        chkIssue("t6_postFlush", 1'b1, 64'h77, 1'b0, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

endmodule
